// File: rtl/dac_cmd_sequencer_if.sv
// rtl/dac_cmd_sequencer_if.sv - command, SPI request and status signals of dac_cmd_sequencer
interface dac_cmd_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_sel;
  logic [23:0]   cmd_word;
  logic          flush;
  logic          spi_wr_req;
  logic [23:0]   spi_wr_data;
  logic          dac_sel;
  logic          spi_ack;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          err_timeout;
  logic          err_clr;

  modport master (
    output cmd_valid, cmd_sel, cmd_word, flush, spi_ack, err_clr,
    input  cmd_ready, spi_wr_req, spi_wr_data, dac_sel, busy, fifo_level, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_word, flush, spi_ack, err_clr,
    output cmd_ready, spi_wr_req, spi_wr_data, dac_sel, busy, fifo_level, err_timeout
  );
endinterface

// File: rtl/dac_cmd_sequencer.sv
// rtl/dac_cmd_sequencer.sv - queues DAC words and issues them to the SPI master with a CSn-high gap
// Optional ack watchdog enabled by defining DAC_SEQ_TIMEOUT_EN.
module dac_cmd_sequencer #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  dac_cmd_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [24:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          req_q, req_d;
  logic          sel_q, sel_d;
  logic [23:0]   data_q, data_d;
  logic [7:0]    gap_q, gap_d;
  logic          full, empty, push, pop, tmo_expire;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // A flush in the same cycle discards the offered command.
  assign push  = bus.cmd_valid && !full && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_sel, bus.cmd_word};
  end

  always_comb begin
    level_d = level_q;
    if (bus.flush)        level_d = '0;
    else if (push && !pop) level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    data_d  = data_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !bus.flush) begin
          pop             = 1'b1;
          {sel_d, data_d} = mem_q[rd_ptr_q];
          req_d           = 1'b1;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.spi_ack || tmo_expire) begin
          req_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = 8'(GAP_CYCLES);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Leaving on a count of 1 yields exactly GAP_CYCLES cycles here.
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

`ifdef DAC_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        err_q;

  // Counter is held at zero outside REQ so every request starts a fresh window.
  assign tmo_expire = (state_q == S_REQ) && !bus.spi_ack &&
                      (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == S_REQ) ? tmo_q + 32'd1 : 32'd0;
      if (tmo_expire)       err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.err_timeout = err_q;
`else
  logic unused_timeout;

  assign tmo_expire      = 1'b0;
  assign bus.err_timeout = 1'b0;
  assign unused_timeout  = ^{bus.err_clr, 32'(TIMEOUT_CYCLES)};
`endif

  assign bus.cmd_ready   = !full;
  assign bus.busy        = (state_q != S_IDLE) || !empty;
  assign bus.fifo_level  = level_q;
  assign bus.spi_wr_req  = req_q;
  assign bus.spi_wr_data = data_q;
  assign bus.dac_sel     = sel_q;
endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// tb/tb_dac_cmd_sequencer.sv - directed self-checking bench for dac_cmd_sequencer
module tb_dac_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int TMO   = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dac_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  dac_cmd_sequencer #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [23:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_word  = w;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!bus.spi_wr_req && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic do_ack(input string tag);
    bus.spi_ack = 1'b1;
    tick();
    bus.spi_ack = 1'b0;
    check({tag, " req drop on ack"}, bus.spi_wr_req, 0);
  endtask

  task automatic expect_issue(input string tag, input logic sel, input logic [23:0] w);
    int n;
    wait_rise(n);
    check({tag, " req"}, bus.spi_wr_req, 1);
    check({tag, " data"}, bus.spi_wr_data, w);
    check({tag, " sel"}, bus.dac_sel, sel);
    repeat (2) tick();
    do_ack(tag);
  endtask

  initial begin
    int n;
    int rises;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 1'b0;
    bus.cmd_word  = '0;
    bus.flush     = 1'b0;
    bus.spi_ack   = 1'b0;
    bus.err_clr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst req", bus.spi_wr_req, 0);
    check("rst data", bus.spi_wr_data, 0);
    check("rst sel", bus.dac_sel, 0);
    check("rst err", bus.err_timeout, 0);
    check("rst level", bus.fifo_level, 0);
    check("rst ready", bus.cmd_ready, 1);
    check("rst busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Single command, then three more queued while the first is in REQ
    push(1'b1, 24'h308000);
    check("single level", bus.fifo_level, 1);
    check("single no req yet", bus.spi_wr_req, 0);
    tick();
    check("single req", bus.spi_wr_req, 1);
    check("single sel", bus.dac_sel, 1);
    check("single data", bus.spi_wr_data, 24'h308000);
    check("single level pop", bus.fifo_level, 0);
    push(1'b0, 24'h111111);
    check("b2b level1", bus.fifo_level, 1);
    push(1'b1, 24'h222222);
    check("b2b level2", bus.fifo_level, 2);
    push(1'b0, 24'h333333);
    check("b2b level3", bus.fifo_level, 3);
    repeat (16) tick();
    check("single held req", bus.spi_wr_req, 1);
    check("single held data", bus.spi_wr_data, 24'h308000);
    do_ack("single");

    wait_rise(n);
    check("b2b gap0", n, GAP + 1);
    check("b2b data0", bus.spi_wr_data, 24'h111111);
    check("b2b sel0", bus.dac_sel, 0);
    check("b2b lvl after pop0", bus.fifo_level, 2);
    repeat (3) tick();
    do_ack("b2b0");
    wait_rise(n);
    check("b2b gap1", n, GAP + 1);
    check("b2b data1", bus.spi_wr_data, 24'h222222);
    check("b2b sel1", bus.dac_sel, 1);
    check("b2b lvl after pop1", bus.fifo_level, 1);
    repeat (5) tick();
    do_ack("b2b1");
    wait_rise(n);
    check("b2b gap2", n, GAP + 1);
    check("b2b data2", bus.spi_wr_data, 24'h333333);
    check("b2b sel2", bus.dac_sel, 0);
    check("b2b lvl after pop2", bus.fifo_level, 0);
    do_ack("b2b2");
    repeat (GAP - 1) tick();
    check("gap busy last", bus.busy, 1);
    tick();
    check("gap idle", bus.busy, 0);

    // Full: one command sits in REQ, eight fill the FIFO, the tenth stalls
    for (int i = 0; i < 9; i++) push(i[0], 24'(24'h400000 + i));
    check("full level", bus.fifo_level, DEPTH);
    check("full ready", bus.cmd_ready, 0);
    check("full head data", bus.spi_wr_data, 24'h400000);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 1'b1;
    bus.cmd_word  = 24'h400009;
    repeat (5) tick();
    check("full stalled level", bus.fifo_level, DEPTH);
    bus.spi_ack = 1'b1;
    tick();
    bus.spi_ack = 1'b0;
    check("full ack req", bus.spi_wr_req, 0);
    check("full no push on ack", bus.fifo_level, DEPTH);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("full ready returns", n, GAP + 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("full refill level", bus.fifo_level, DEPTH);
    for (int i = 1; i < 10; i++) expect_issue("full drain", i[0], 24'(24'h400000 + i));
    check("full drained level", bus.fifo_level, 0);
    repeat (GAP + 2) tick();
    check("full idle", bus.busy, 0);

    // Flush while the first command is in REQ, with a push in the flush cycle
    for (int i = 0; i < 4; i++) push(i[0], 24'(24'h5A0000 + i));
    check("flush pre level", bus.fifo_level, 3);
    check("flush pre req", bus.spi_wr_req, 1);
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = 24'hDEAD00;
    check("flush ready", bus.cmd_ready, 1);
    tick();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    check("flush level", bus.fifo_level, 0);
    check("flush keeps req", bus.spi_wr_req, 1);
    check("flush keeps data", bus.spi_wr_data, 24'h5A0000);
    do_ack("flush");
    rises = 0;
    repeat (40) begin
      tick();
      if (bus.spi_wr_req) rises++;
    end
    check("flush no further req", rises, 0);
    check("flush idle", bus.busy, 0);

    // Asynchronous reset in the middle of REQ
    push(1'b1, 24'h6B0000);
    tick();
    push(1'b0, 24'h6B0001);
    push(1'b0, 24'h6B0002);
    check("arst pre req", bus.spi_wr_req, 1);
    check("arst pre level", bus.fifo_level, 2);
    rst_n = 1'b0;
    #1;
    check("arst req", bus.spi_wr_req, 0);
    check("arst level", bus.fifo_level, 0);
    check("arst data", bus.spi_wr_data, 0);
    check("arst sel", bus.dac_sel, 0);
    check("arst busy", bus.busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    push(1'b1, 24'h7C0003);
    check("arst after no req", bus.spi_wr_req, 0);
    tick();
    check("arst after req", bus.spi_wr_req, 1);
    check("arst after data", bus.spi_wr_data, 24'h7C0003);
    check("arst after sel", bus.dac_sel, 1);
    do_ack("arst");
    repeat (GAP + 2) tick();

`ifdef DAC_SEQ_TIMEOUT_EN
    push(1'b0, 24'h0A0001);
    push(1'b1, 24'h0A0002);
    check("tmo req", bus.spi_wr_req, 1);
    n = 0;
    while (bus.spi_wr_req && n < 300) begin
      tick();
      n++;
    end
    check("tmo fall cycles", n, TMO);
    check("tmo err set", bus.err_timeout, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo err clr", bus.err_timeout, 0);
    wait_rise(n);
    check("tmo next gap", n, GAP);
    check("tmo next data", bus.spi_wr_data, 24'h0A0002);
    check("tmo next sel", bus.dac_sel, 1);
    do_ack("tmo");
`else
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("no tmo err", bus.err_timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
